fill_sequencer: RTL and testbench

FILL_SEQUENCER -- requirements
Module: fill_sequencer

---
 rtl/fill_sequencer.sv | 158 +++++++++++++++
 tb/tb_fill_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_sequencer.sv
// fill_sequencer
//   Two-requester fill-pattern burst generator. In IDLE a round-robin arbiter
//   grants one requester, latching its fill kind, cast width and length. The
//   module then emits len+1 identical beats on a valid/ready output port.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   reqN_valid/ready     : request handshake for requester N (N = 0, 1)
//   reqN_kind            : 0 zero, 1 one, 2 unknown, 3 high-impedance
//   reqN_cast            : cast width (0 or >= WIDTH means full width)
//   reqN_len             : beats minus one
//   flush                : abort current burst / suppress grants in IDLE
//   out_valid/out_ready  : output beat handshake
//   out_data/known/oe    : per-bit value, defined flag, drive enable
//   out_last, out_src    : final beat flag, owning requester
//   busy                 : FSM is in BURST
module fill_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_kind,
    input  logic [7:0]       req0_cast,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_kind,
    input  logic [7:0]       req1_cast,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_known,
    output logic [WIDTH-1:0] out_oe,
    output logic             out_last,
    output logic             out_src,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               src_q, src_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   known_q, known_d;
    logic [WIDTH-1:0]   oe_q, oe_d;

    logic               grant1;
    logic               do_grant;
    logic               hs;
    logic [1:0]         sel_kind;
    logic [7:0]         sel_cast;
    logic [LEN_W-1:0]   sel_len;
    int                 cast_w;
    logic               in_cast;
    logic [WIDTH-1:0]   pat_data, pat_known, pat_oe;

    always_comb begin
        // With both valid the priority holder wins; otherwise whoever is valid.
        grant1   = (req0_valid && req1_valid) ? prio_q : req1_valid;
        do_grant = (state_q == StIdle) && !rst && !flush && (req0_valid || req1_valid);
        req0_ready = do_grant && !grant1;
        req1_ready = do_grant && grant1;

        sel_kind = grant1 ? req1_kind : req0_kind;
        sel_cast = grant1 ? req1_cast : req0_cast;
        sel_len  = grant1 ? req1_len  : req0_len;

        cast_w = ((sel_cast != 8'd0) && (int'(sel_cast) < int'(WIDTH))) ?
                 int'(sel_cast) : int'(WIDTH);

        // Bits above the cast width are zero-extended: defined, driven 0.
        pat_data  = '0;
        pat_known = '0;
        pat_oe    = '0;
        in_cast   = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            in_cast      = (i < cast_w);
            pat_data[i]  = in_cast && (sel_kind == 2'd1);
            pat_known[i] = !in_cast || !sel_kind[1];
            pat_oe[i]    = !in_cast || (sel_kind != 2'd3);
        end

        hs = (state_q == StBurst) && out_ready;

        state_d = state_q;
        prio_d  = prio_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        known_d = known_q;
        oe_d    = oe_q;

        case (state_q)
            StIdle: begin
                if (do_grant) begin
                    state_d = StBurst;
                    prio_d  = !grant1;
                    src_d   = grant1;
                    cnt_d   = sel_len;
                    data_d  = pat_data;
                    known_d = pat_known;
                    oe_d    = pat_oe;
                end
            end
            StBurst: begin
                // Flush wins over an in-flight handshake; priority untouched.
                if (flush || (hs && (cnt_q == '0))) begin
                    state_d = StIdle;
                    src_d   = 1'b0;
                    cnt_d   = '0;
                    data_d  = '0;
                    known_d = '0;
                    oe_d    = '0;
                end else if (hs) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            known_q <= '0;
            oe_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            known_q <= known_d;
            oe_q    <= oe_d;
        end
    end

    // Beat registers are cleared on leaving BURST, so they read 0 when idle.
    assign busy      = (state_q == StBurst);
    assign out_valid = busy;
    assign out_last  = busy && (cnt_q == '0);
    assign out_src   = src_q;
    assign out_data  = data_q;
    assign out_known = known_q;
    assign out_oe    = oe_q;

endmodule

// File: tb/tb_fill_sequencer.sv
module tb_fill_sequencer;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_kind = '0, req1_kind = '0;
    logic [7:0]   req0_cast = '0, req1_cast = '0;
    logic [7:0]   req0_len = '0, req1_len = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data, out_known, out_oe;
    logic         out_last, out_src, busy;

    fill_sequencer #(.WIDTH(W), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_kind(req0_kind),
        .req0_cast(req0_cast), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_kind(req1_kind),
        .req1_cast(req1_cast), .req1_len(req1_len),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_known(out_known), .out_oe(out_oe),
        .out_last(out_last), .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         src;
        logic [1:0]   kind;
        logic [7:0]   cast;
        logic [7:0]   len;
        logic [W-1:0] e_data;
        logic [W-1:0] e_known;
        logic [W-1:0] e_oe;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] k;
        logic [W-1:0] o;
        logic         last;
        logic         src;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    hs_cnt = 0;
    int    last_cnt = 0;
    logic  sb_en = 1'b1;
    logic  tog = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // out_ready: held high, or toggled every cycle when tog is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = tog ? ~out_ready : 1'b1;
        end
    end

    // Monitor and scoreboard.
    logic         prev_v = 1'b0, prev_r = 1'b0;
    logic [W-1:0] prev_d, prev_k, prev_o;
    logic         prev_l, prev_s;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            check("ready_excl", {255'd0, req0_ready & req1_ready}, 256'd0);
            check("ready_in_burst", {255'd0, (req0_ready | req1_ready) & busy}, 256'd0);
            if (!out_valid)
                check("idle_zero", {out_data | out_known | out_oe, out_last, out_src}, 256'd0);
            if (prev_v && !prev_r && out_valid) begin
                check("stall_data", out_data, prev_d);
                check("stall_known", out_known, prev_k);
                check("stall_oe", out_oe, prev_o);
                check("stall_last_src", {out_last, out_src}, {prev_l, prev_s});
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (out_last) last_cnt++;
                if (sb_en) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 256'd1, 256'd0);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        check("beat_data", out_data, e.d);
                        check("beat_known", out_known, e.k);
                        check("beat_oe", out_oe, e.o);
                        check("beat_last", {255'd0, out_last}, {255'd0, e.last});
                        check("beat_src", {255'd0, out_src}, {255'd0, e.src});
                    end
                end
            end
            prev_v = out_valid; prev_r = out_ready;
            prev_d = out_data; prev_k = out_known; prev_o = out_oe;
            prev_l = out_last; prev_s = out_src;
        end
    end

    task automatic push_beats(input logic src, input logic [W-1:0] d, input logic [W-1:0] k,
                              input logic [W-1:0] o, input int len);
        for (int b = 0; b <= len; b++) sb.push_back('{d: d, k: k, o: o, last: (b == len), src: src});
    endtask

    task automatic drive_req(input logic src, input logic v, input logic [1:0] kind,
                             input logic [7:0] cast, input logic [7:0] len);
        if (src) begin
            req1_valid = v; req1_kind = kind; req1_cast = cast; req1_len = len;
        end else begin
            req0_valid = v; req0_kind = kind; req0_cast = cast; req0_len = len;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while ((busy || sb.size() != 0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", {255'd0, k < limit}, 256'd1);
    endtask

    task automatic wait_ready(input logic src, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(src ? req1_ready : req0_ready) && k < 20);
        check(name, {254'd0, req1_ready, req0_ready}, src ? 256'd2 : 256'd1);
    endtask

    task automatic send(input vec_t v);
        push_beats(v.src, v.e_data, v.e_known, v.e_oe, int'(v.len));
        @(posedge clk); #1;
        drive_req(v.src, 1'b1, v.kind, v.cast, v.len);
        wait_ready(v.src, "grant_ready");
        @(posedge clk); #1;
        drive_req(v.src, 1'b0, v.kind, v.cast, v.len);
        wait_drain(1000);
    endtask

    vec_t vecs[8];

    initial begin
        int h0;
        int l0;
        vecs[0] = '{1'b0, 2'd1, 8'd3,   8'd0, 64'h7, ONES, ONES};
        vecs[1] = '{1'b1, 2'd3, 8'd0,   8'd2, 64'h0, 64'h0, 64'h0};
        vecs[2] = '{1'b0, 2'd0, 8'd8,   8'd1, 64'h0, ONES, ONES};
        vecs[3] = '{1'b1, 2'd2, 8'd200, 8'd4, 64'h0, 64'h0, ONES};
        vecs[4] = '{1'b0, 2'd2, 8'd4,   8'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, ONES};
        vecs[5] = '{1'b1, 2'd3, 8'd63,  8'd0, 64'h0, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000};
        vecs[6] = '{1'b0, 2'd1, 8'd64,  8'd0, ONES, ONES, ONES};
        vecs[7] = '{1'b1, 2'd1, 8'd1,   8'd0, 64'h1, ONES, ONES};

        // Reset state (checked while rst is still asserted).
        @(negedge clk);
        check("reset_outs", {out_valid, busy, req0_ready, req1_ready, out_last, out_src},
              256'd0);
        check("reset_data", out_data | out_known | out_oe, 256'd0);
        do_reset();

        for (int i = 0; i < 8; i++) send(vecs[i]);

        // Round-robin with both requesters held valid.
        do_reset();
        for (int b = 0; b < 4; b++) push_beats(b[0], 64'h0, ONES, ONES, 0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'd0, 8'd0, 8'd0);
        drive_req(1'b1, 1'b1, 2'd0, 8'd0, 8'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rr_ready", {253'd0, out_valid, req1_ready, req0_ready},
                  {253'd0, c[0], c % 4 == 2, c % 4 == 0});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain(100);

        // Stalls: out_ready toggles, beat must hold while stalled.
        h0 = hs_cnt;
        tog = 1'b1;
        send('{1'b0, 2'd2, 8'd200, 8'd4, 64'h0, 64'h0, ONES});
        tog = 1'b0;
        check("stall_beats", hs_cnt - h0, 256'd5);

        // Reset in the middle of a len-7 burst owned by requester 0.
        do_reset();
        sb_en = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'd1, 8'd0, 8'd7);
        wait_ready(1'b0, "t5_grant");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_burst", {255'd0, out_valid}, 256'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_outs", {out_valid, busy, req0_ready, req1_ready, out_last, out_src}, 256'd0);
        check("t5_data", out_data | out_known | out_oe, 256'd0);
        sb.delete();
        sb_en = 1'b1;
        push_beats(1'b0, 64'h0, ONES, ONES, 0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'd0, 8'd0, 8'd0);
        drive_req(1'b1, 1'b1, 2'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("t5_post_grant", {254'd0, req1_ready, req0_ready}, 256'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain(100);

        // Flush on the handshake of the second beat of a len-3 burst.
        do_reset();
        sb_en = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'd0, 8'd0, 8'd3);
        wait_ready(1'b0, "t6_grant");
        h0 = hs_cnt;
        l0 = last_cnt;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_beat", {254'd0, out_valid, out_ready}, 256'd3);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t6_busy", {254'd0, busy, out_valid}, 256'd0);
        repeat (3) @(negedge clk);
        check("t6_beats", hs_cnt - h0, 256'd2);
        check("t6_no_last", last_cnt - l0, 256'd0);
        // Flush in IDLE blocks grants; priority (now requester 1) is unchanged.
        sb_en = 1'b1;
        push_beats(1'b1, 64'h0, ONES, ONES, 0);
        @(posedge clk); #1;
        flush = 1'b1;
        drive_req(1'b0, 1'b1, 2'd0, 8'd0, 8'd0);
        drive_req(1'b1, 1'b1, 2'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("idle_flush", {254'd0, req1_ready, req0_ready}, 256'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t6_prio", {254'd0, req1_ready, req0_ready}, 256'd2);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
